// File: rtl/fence_pkg.sv
// Shared types and constants for the fencing action/scoring blocks.
package fence_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2,
        PAUSE    = 2'd3
    } action_state_t;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_WINDOW = 1'b1
    } resolve_state_t;

    localparam logic [31:0] BLOCK_CODE = 32'hDEADBEEF;
    localparam logic [31:0] LUNGE_CODE = 32'h20FACADE;

    // Point owner encoding: bit0 = this player, bit1 = opponent.
    localparam logic [1:0] OWNER_NONE   = 2'b00;
    localparam logic [1:0] OWNER_PLAYER = 2'b01;
    localparam logic [1:0] OWNER_OPP    = 2'b10;
    localparam logic [1:0] OWNER_BOTH   = 2'b11;

    function automatic int cnt_max(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/touch_resolver.sv
// Merges local and remote touches inside a double-touch window and keeps both scores.
// Written from this board's viewpoint; swap the touch inputs to reuse on the opponent's board.
module touch_resolver
    import fence_pkg::*;
#(
    parameter int TOUCH_WINDOW = 20,
    parameter int WIN_SCORE    = 15,
    parameter int SCORE_W      = $clog2(WIN_SCORE + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               local_touch_i,
    input  logic               remote_touch_i,
    input  logic               hold_i,
    output logic               point_valid_o,
    output logic [1:0]         point_who_o,
    output logic [SCORE_W-1:0] local_score_o,
    output logic [SCORE_W-1:0] remote_score_o,
    output logic               match_over_o
);

    localparam int                   WIN_CNT_W   = $clog2(TOUCH_WINDOW + 1);
    localparam logic [WIN_CNT_W-1:0] WIN_LAST    = WIN_CNT_W'(TOUCH_WINDOW - 1);
    localparam logic [SCORE_W-1:0]   WIN_SCORE_V = SCORE_W'(WIN_SCORE);

    resolve_state_t       state_q, state_d;
    logic [WIN_CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [1:0]           owner_q, owner_d;
    logic [SCORE_W-1:0]   local_score_q, local_score_d;
    logic [SCORE_W-1:0]   remote_score_q, remote_score_d;
    logic                 match_over_q, match_over_d;
    logic                 point_valid_q;
    logic [1:0]           point_who_q;
    logic                 ignore_s;
    logic                 opposite_s;
    logic                 award_s;
    logic [1:0]           award_who_s;

    // Touches are dropped on the award cycle itself, during the freeze and once the match is decided.
    assign ignore_s = hold_i | point_valid_q | match_over_q;

    // Window sequencing and award decision.
    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        owner_d     = owner_q;
        award_s     = 1'b0;
        award_who_s = OWNER_NONE;
        opposite_s  = 1'b0;
        if (owner_q == OWNER_PLAYER) begin
            opposite_s = remote_touch_i;
        end else begin
            opposite_s = local_touch_i;
        end
        if (ignore_s) begin
            state_d = R_IDLE;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (local_touch_i && remote_touch_i) begin
                        award_s     = 1'b1;
                        award_who_s = OWNER_BOTH;
                    end else if (local_touch_i || remote_touch_i) begin
                        state_d   = R_WINDOW;
                        win_cnt_d = WIN_LAST;
                        owner_d   = local_touch_i ? OWNER_PLAYER : OWNER_OPP;
                    end else begin
                        state_d = R_IDLE;
                    end
                end
                R_WINDOW: begin
                    if (opposite_s) begin
                        award_s     = 1'b1;
                        award_who_s = OWNER_BOTH;
                        state_d     = R_IDLE;
                    end else if (win_cnt_q == '0) begin
                        award_s     = 1'b1;
                        award_who_s = owner_q;
                        state_d     = R_IDLE;
                    end else begin
                        win_cnt_d = win_cnt_q - WIN_CNT_W'(1);
                    end
                end
                default: begin
                    state_d = R_IDLE;
                end
            endcase
        end
    end

    // Saturating score update and sticky match-over.
    always_comb begin
        local_score_d  = local_score_q;
        remote_score_d = remote_score_q;
        if (award_s && award_who_s[0] && (local_score_q != WIN_SCORE_V)) begin
            local_score_d = local_score_q + SCORE_W'(1);
        end else begin
            local_score_d = local_score_q;
        end
        if (award_s && award_who_s[1] && (remote_score_q != WIN_SCORE_V)) begin
            remote_score_d = remote_score_q + SCORE_W'(1);
        end else begin
            remote_score_d = remote_score_q;
        end
        match_over_d = match_over_q | (local_score_d == WIN_SCORE_V) | (remote_score_d == WIN_SCORE_V);
    end

    // Resolver state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= R_IDLE;
            win_cnt_q      <= '0;
            owner_q        <= OWNER_NONE;
            local_score_q  <= '0;
            remote_score_q <= '0;
            match_over_q   <= 1'b0;
            point_valid_q  <= 1'b0;
            point_who_q    <= OWNER_NONE;
        end else begin
            state_q        <= state_d;
            win_cnt_q      <= win_cnt_d;
            owner_q        <= owner_d;
            local_score_q  <= local_score_d;
            remote_score_q <= remote_score_d;
            match_over_q   <= match_over_d;
            point_valid_q  <= award_s;
            point_who_q    <= award_who_s;
        end
    end

    assign point_valid_o  = point_valid_q;
    assign point_who_o    = point_who_q;
    assign local_score_o  = local_score_q;
    assign remote_score_o = remote_score_q;
    assign match_over_o   = match_over_q;

endmodule

// File: rtl/action_arbiter.sv
// Per-player action engine: decodes IR codes into actions, times active/cooldown
// phases, decides landing of attacks and freezes play after each awarded point.
module action_arbiter
    import fence_pkg::*;
#(
    parameter int                              CODE_WIDTH      = 32,
    parameter int                              N_ACTIONS       = 2,
    parameter logic [N_ACTIONS*CODE_WIDTH-1:0] ACTION_CODES    = {LUNGE_CODE, BLOCK_CODE},
    parameter logic [N_ACTIONS-1:0]            ATTACK_MASK     = 2'b10,
    parameter int                              DIST_WIDTH      = 11,
    parameter int                              REACH           = 100,
    parameter int                              ACTIVE_CYCLES   = 30,
    parameter int                              COOLDOWN_CYCLES = 60,
    parameter int                              TOUCH_WINDOW    = 20,
    parameter int                              PAUSE_CYCLES    = 120,
    parameter int                              WIN_SCORE       = 15,
    parameter int                              IDX_W           = $clog2(N_ACTIONS + 1),
    parameter int                              SCORE_W         = $clog2(WIN_SCORE + 1)
) (
    input  logic                  clk_pixel_in,
    input  logic                  rst_n_in,
    input  logic [CODE_WIDTH-1:0] ir_code_in,
    input  logic                  ir_valid_in,
    input  logic [DIST_WIDTH-1:0] distance_in,
    input  logic                  opp_defending_in,
    input  logic                  opp_touch_in,
    output logic [IDX_W-1:0]      action_out,
    output logic                  action_active_out,
    output logic                  defending_out,
    output logic                  cooldown_out,
    output logic                  touch_out,
    output logic                  point_valid_out,
    output logic [1:0]            point_who_out,
    output logic [SCORE_W-1:0]    player_score_out,
    output logic [SCORE_W-1:0]    opp_score_out,
    output logic                  match_over_out
);

    localparam int                    CNT_MAX       = cnt_max(ACTIVE_CYCLES, COOLDOWN_CYCLES, PAUSE_CYCLES);
    localparam int                    CNT_W         = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]      ACTIVE_LAST   = CNT_W'(ACTIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      COOLDOWN_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0]      PAUSE_LAST    = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [DIST_WIDTH-1:0] REACH_V       = DIST_WIDTH'(REACH);

    action_state_t    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] action_q;
    logic             active_q;
    logic             defending_q;
    logic             cooldown_q;
    logic             touch_q;
    logic             landed_q;
    logic             attack_q;
    logic [IDX_W-1:0] match_idx_s;
    logic             match_attack_s;
    logic             land_s;
    logic             pause_s;
    logic             point_valid_s;
    logic             match_over_s;

    // Code lookup; scanning downwards leaves the lowest matching index in place.
    always_comb begin
        match_idx_s    = '0;
        match_attack_s = 1'b0;
        for (int i = N_ACTIONS; i >= 1; i--) begin
            if (ir_code_in == ACTION_CODES[(i-1)*CODE_WIDTH +: CODE_WIDTH]) begin
                match_idx_s    = IDX_W'(i);
                match_attack_s = ATTACK_MASK[i-1];
            end else begin
                match_idx_s    = match_idx_s;
                match_attack_s = match_attack_s;
            end
        end
    end

    assign land_s  = (state_q == ACTIVE) && attack_q && !landed_q &&
                     (distance_in <= REACH_V) && !opp_defending_in;
    assign pause_s = (state_q == PAUSE);

    // Action FSM with registered outputs; an awarded point overrides every state.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            action_q    <= '0;
            active_q    <= 1'b0;
            defending_q <= 1'b0;
            cooldown_q  <= 1'b0;
            touch_q     <= 1'b0;
            landed_q    <= 1'b0;
            attack_q    <= 1'b0;
        end else if (point_valid_s) begin
            state_q     <= PAUSE;
            cnt_q       <= PAUSE_LAST;
            action_q    <= '0;
            active_q    <= 1'b0;
            defending_q <= 1'b0;
            cooldown_q  <= 1'b0;
            touch_q     <= 1'b0;
            landed_q    <= 1'b0;
            attack_q    <= 1'b0;
        end else begin
            touch_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ir_valid_in && (match_idx_s != '0) && !match_over_s) begin
                        state_q     <= ACTIVE;
                        cnt_q       <= ACTIVE_LAST;
                        action_q    <= match_idx_s;
                        active_q    <= 1'b1;
                        defending_q <= !match_attack_s;
                        attack_q    <= match_attack_s;
                        landed_q    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (land_s) begin
                        touch_q  <= 1'b1;
                        landed_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q     <= COOLDOWN;
                        cnt_q       <= COOLDOWN_LAST;
                        action_q    <= '0;
                        active_q    <= 1'b0;
                        defending_q <= 1'b0;
                        cooldown_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                COOLDOWN: begin
                    if (cnt_q == '0) begin
                        state_q    <= IDLE;
                        cooldown_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                PAUSE: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    action_q    <= '0;
                    active_q    <= 1'b0;
                    defending_q <= 1'b0;
                    cooldown_q  <= 1'b0;
                end
            endcase
        end
    end

    touch_resolver #(
        .TOUCH_WINDOW (TOUCH_WINDOW),
        .WIN_SCORE    (WIN_SCORE),
        .SCORE_W      (SCORE_W)
    ) u_touch_resolver (
        .clk_i          (clk_pixel_in),
        .rst_n_i        (rst_n_in),
        .local_touch_i  (touch_q),
        .remote_touch_i (opp_touch_in),
        .hold_i         (pause_s),
        .point_valid_o  (point_valid_s),
        .point_who_o    (point_who_out),
        .local_score_o  (player_score_out),
        .remote_score_o (opp_score_out),
        .match_over_o   (match_over_s)
    );

    assign action_out        = action_q;
    assign action_active_out = active_q;
    assign defending_out     = defending_q;
    assign cooldown_out      = cooldown_q;
    assign touch_out         = touch_q;
    assign point_valid_out   = point_valid_s;
    assign match_over_out    = match_over_s;

endmodule

// File: tb/tb_action_arbiter.sv
// Self-checking bench for action_arbiter: randomized scenarios scored against event-time expectations.
module tb_action_arbiter;

    localparam int A   = 4;
    localparam int C   = 3;
    localparam int W   = 5;
    localparam int P   = 8;
    localparam int NS  = 96;
    localparam logic [31:0] LUNGE = 32'h20FACADE;
    localparam logic [31:0] BLOCK = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ir_code = 32'd0;
    logic        ir_valid = 1'b0;
    logic [10:0] distance = 11'd0;
    logic        opp_def = 1'b0;
    logic        opp_touch = 1'b0;
    logic [1:0]  action;
    logic        active, defending, cooldown, touch, pv, mo;
    logic [1:0]  who, ps, os;

    int checks = 0;
    int failures = 0;

    // Stimulus per cycle index, and outputs captured just after that cycle's clock edge.
    logic        s_irv [NS];
    logic [31:0] s_code[NS];
    logic [10:0] s_dist[NS];
    logic        s_def [NS];
    logic        s_ot  [NS];
    logic [1:0]  o_act [NS];
    logic        o_active[NS], o_defd[NS], o_cool[NS], o_touch[NS], o_pv[NS], o_mo[NS];
    logic [1:0]  o_who[NS], o_ps[NS], o_os[NS];

    always #5 clk = ~clk;

    action_arbiter #(
        .ACTIVE_CYCLES   (A),
        .COOLDOWN_CYCLES (C),
        .TOUCH_WINDOW    (W),
        .PAUSE_CYCLES    (P),
        .REACH           (100),
        .WIN_SCORE       (3)
    ) dut (
        .clk_pixel_in      (clk),
        .rst_n_in          (rst_n),
        .ir_code_in        (ir_code),
        .ir_valid_in       (ir_valid),
        .distance_in       (distance),
        .opp_defending_in  (opp_def),
        .opp_touch_in      (opp_touch),
        .action_out        (action),
        .action_active_out (active),
        .defending_out     (defending),
        .cooldown_out      (cooldown),
        .touch_out         (touch),
        .point_valid_out   (pv),
        .point_who_out     (who),
        .player_score_out  (ps),
        .opp_score_out     (os),
        .match_over_out    (mo)
    );

    task automatic zero_inputs();
        ir_valid = 1'b0; ir_code = 32'd0; distance = 11'd2047; opp_def = 1'b0; opp_touch = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_stim();
        for (int k = 0; k < NS; k++) begin
            s_irv[k] = 1'b0; s_code[k] = 32'd0; s_dist[k] = 11'd2047; s_def[k] = 1'b0; s_ot[k] = 1'b0;
        end
    endtask

    task automatic run_steps(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ir_valid = s_irv[k]; ir_code = s_code[k]; distance = s_dist[k];
            opp_def = s_def[k]; opp_touch = s_ot[k];
            @(posedge clk);
            #1;
            o_act[k] = action; o_active[k] = active; o_defd[k] = defending; o_cool[k] = cooldown;
            o_touch[k] = touch; o_pv[k] = pv; o_who[k] = who; o_ps[k] = ps; o_os[k] = os; o_mo[k] = mo;
        end
        @(negedge clk);
        zero_inputs();
    endtask

    task automatic test_reset();
        logic [31:0] code;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({action, active, defending, cooldown, touch} !== 6'd0) begin
            failures++; $display("FAIL reset_action got=%b want=0", {action, active, defending, cooldown, touch});
        end
        checks++;
        if ({pv, who, ps, os, mo} !== 8'd0) begin
            failures++; $display("FAIL reset_score got=%b want=0", {pv, who, ps, os, mo});
        end
        do_reset();
        clear_stim();
        for (int k = 1; k < 8; k++) begin
            code = $urandom;
            if (code == LUNGE || code == BLOCK) code = 32'h0000_0001;
            s_irv[k] = 1'b1; s_code[k] = code; s_dist[k] = 11'd0;
        end
        run_steps(12);
        for (int k = 0; k < 12; k++) begin
            checks++;
            if ({o_act[k], o_active[k], o_touch[k], o_pv[k]} !== 5'd0) begin
                failures++; $display("FAIL unmatched_code k=%0d got=%b want=0", k, {o_act[k], o_active[k], o_touch[k], o_pv[k]});
            end
        end
    endtask

    task automatic test_lunge_lands();
        int t0, lc, pt, re, n;
        logic e_act, e_cool;
        do_reset(); clear_stim();
        t0 = $urandom_range(2, 6);
        lc = t0 + $urandom_range(1, A);
        s_irv[t0] = 1'b1; s_code[t0] = LUNGE;
        for (int k = t0 + 1; k < lc; k++) begin
            if ($urandom_range(0, 1) == 1) s_dist[k] = 11'($urandom_range(101, 2047));
            else begin s_dist[k] = 11'($urandom_range(0, 100)); s_def[k] = 1'b1; end
        end
        s_dist[lc] = 11'($urandom_range(0, 100));
        for (int k = lc + 1; k <= lc + 6; k++) s_dist[k] = 11'($urandom_range(0, 2047));
        pt = lc + 1 + W;
        s_irv[pt + 9] = 1'b1; s_code[pt + 9] = LUNGE;
        re = pt + 10;
        s_irv[re] = 1'b1; s_code[re] = LUNGE;
        n = re + A + C + 3;
        run_steps(n);
        for (int k = 0; k < n; k++) begin
            e_act  = (k >= t0 && k < t0 + A) || (k >= re && k < re + A);
            e_cool = (k >= t0 + A && k < t0 + A + C) || (k >= re + A && k < re + A + C);
            checks++;
            if (o_active[k] !== e_act || o_act[k] !== (e_act ? 2'd2 : 2'd0) || o_defd[k] !== 1'b0) begin
                failures++; $display("FAIL lunge_active k=%0d got=%b/%0d want=%b", k, o_active[k], o_act[k], e_act);
            end
            checks++;
            if (o_cool[k] !== e_cool) begin
                failures++; $display("FAIL lunge_cooldown k=%0d got=%b want=%b", k, o_cool[k], e_cool);
            end
            checks++;
            if (o_touch[k] !== (k == lc) || o_pv[k] !== (k == pt)) begin
                failures++; $display("FAIL lunge_touch_point k=%0d got=%b%b want=%b%b", k, o_touch[k], o_pv[k], k == lc, k == pt);
            end
            checks++;
            if (o_ps[k] !== ((k >= pt) ? 2'd1 : 2'd0) || o_os[k] !== 2'd0) begin
                failures++; $display("FAIL lunge_score k=%0d got=%0d/%0d", k, o_ps[k], o_os[k]);
            end
        end
        checks++;
        if (o_who[pt] !== 2'b01) begin
            failures++; $display("FAIL lunge_who got=%b want=01", o_who[pt]);
        end
    endtask

    task automatic test_blocked_lunge();
        int t0, cd, nb, n;
        logic [1:0] e_act;
        logic e_cool;
        logic [31:0] code;
        do_reset(); clear_stim();
        t0 = $urandom_range(3, 8);
        code = $urandom;
        if (code == LUNGE || code == BLOCK) code = 32'h1234_5678;
        s_irv[1] = 1'b1; s_code[1] = code;
        s_irv[t0] = 1'b1; s_code[t0] = LUNGE;
        for (int k = 0; k < NS; k++) begin s_def[k] = 1'b1; s_dist[k] = 11'($urandom_range(0, 100)); end
        cd = t0 + A + 1 + $urandom_range(0, C - 1);
        s_irv[cd] = 1'b1; s_code[cd] = LUNGE;
        nb = t0 + A + C + 1;
        s_irv[nb] = 1'b1; s_code[nb] = BLOCK;
        n = nb + A + C + 4;
        run_steps(n);
        for (int k = 0; k < n; k++) begin
            e_act  = (k >= t0 && k < t0 + A) ? 2'd2 : ((k >= nb && k < nb + A) ? 2'd1 : 2'd0);
            e_cool = (k >= t0 + A && k < t0 + A + C) || (k >= nb + A && k < nb + A + C);
            checks++;
            if (o_act[k] !== e_act || o_active[k] !== (e_act != 2'd0) || o_defd[k] !== (e_act == 2'd1)) begin
                failures++; $display("FAIL blocked_action k=%0d got=%0d/%b/%b want=%0d", k, o_act[k], o_active[k], o_defd[k], e_act);
            end
            checks++;
            if (o_cool[k] !== e_cool || o_touch[k] !== 1'b0 || o_pv[k] !== 1'b0) begin
                failures++; $display("FAIL blocked_cool_touch k=%0d got=%b%b%b want=%b00", k, o_cool[k], o_touch[k], o_pv[k], e_cool);
            end
        end
    endtask

    task automatic test_double_touch();
        int t0, tt, g, c, pt, n;
        logic [1:0] e_who, e_ps, e_os;
        for (int part = 0; part < 3; part++) begin
            do_reset(); clear_stim();
            t0 = $urandom_range(2, 5);
            tt = t0 + 2;
            if (part == 0) begin
                s_irv[t0] = 1'b1; s_code[t0] = LUNGE; s_dist[t0 + 1] = 11'($urandom_range(0, 100));
                g = $urandom_range(1, W + 1);
                s_ot[tt + g] = 1'b1;
                if (g <= W) begin pt = tt + g; e_who = 2'b11; e_ps = 2'd1; e_os = 2'd1; end
                else begin pt = tt + W; e_who = 2'b01; e_ps = 2'd1; e_os = 2'd0; end
            end else if (part == 1) begin
                c = $urandom_range(2, 6);
                s_ot[c] = 1'b1;
                s_ot[c + $urandom_range(1, W - 1)] = 1'b1;
                pt = c + W; e_who = 2'b10; e_ps = 2'd0; e_os = 2'd1;
            end else begin
                s_irv[t0] = 1'b1; s_code[t0] = LUNGE; s_dist[t0 + 1] = 11'($urandom_range(0, 100));
                s_ot[tt] = 1'b1;
                pt = tt; e_who = 2'b11; e_ps = 2'd1; e_os = 2'd1;
            end
            n = pt + P + 6;
            run_steps(n);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (o_pv[k] !== (k == pt)) begin
                    failures++; $display("FAIL double_point part=%0d k=%0d got=%b want=%b", part, k, o_pv[k], k == pt);
                end
            end
            checks++;
            if (o_who[pt] !== e_who) begin
                failures++; $display("FAIL double_who part=%0d got=%b want=%b", part, o_who[pt], e_who);
            end
            checks++;
            if (o_ps[n - 1] !== e_ps || o_os[n - 1] !== e_os) begin
                failures++; $display("FAIL double_score part=%0d got=%0d/%0d want=%0d/%0d", part, o_ps[n - 1], o_os[n - 1], e_ps, e_os);
            end
        end
    endtask

    task automatic test_reach_boundary();
        int t0, n, lt;
        for (int part = 0; part < 2; part++) begin
            do_reset(); clear_stim();
            t0 = $urandom_range(2, 6);
            s_irv[t0] = 1'b1; s_code[t0] = LUNGE;
            for (int k = 0; k < NS; k++) s_dist[k] = 11'd101;
            if (part == 1) for (int k = t0 + 3; k < NS; k++) s_dist[k] = 11'd100;
            lt = (part == 1) ? t0 + 3 : -1;
            n = t0 + 4 + W + 4;
            run_steps(n);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (o_touch[k] !== (k == lt)) begin
                    failures++; $display("FAIL reach_touch part=%0d k=%0d got=%b want=%b", part, k, o_touch[k], k == lt);
                end
                checks++;
                if (o_pv[k] !== (part == 1 && k == t0 + 4 + W)) begin
                    failures++; $display("FAIL reach_point part=%0d k=%0d got=%b", part, k, o_pv[k]);
                end
            end
        end
    endtask

    task automatic test_match_over();
        int pts;
        int lunges[3];
        logic e_act;
        do_reset(); clear_stim();
        lunges[0] = 2; lunges[1] = 22; lunges[2] = 42;
        for (int i = 0; i < 3; i++) begin
            s_irv[lunges[i]] = 1'b1; s_code[lunges[i]] = LUNGE;
            s_dist[lunges[i] + 1] = 11'($urandom_range(0, 100));
        end
        s_irv[62] = 1'b1; s_code[62] = LUNGE; s_dist[63] = 11'd0;
        s_ot[70] = 1'b1; s_ot[75] = 1'b1;
        run_steps(90);
        for (int k = 0; k < 90; k++) begin
            pts = 0;
            e_act = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (k >= lunges[i] + 7) pts++;
                if (k >= lunges[i] && k < lunges[i] + A) e_act = 1'b1;
            end
            checks++;
            if (o_ps[k] !== 2'(pts) || o_os[k] !== 2'd0 || o_mo[k] !== (pts == 3)) begin
                failures++; $display("FAIL match_score k=%0d got=%0d/%0d/%b want=%0d/0/%b", k, o_ps[k], o_os[k], o_mo[k], pts, pts == 3);
            end
            checks++;
            if (o_active[k] !== e_act || o_pv[k] !== (k == 9 || k == 29 || k == 49)) begin
                failures++; $display("FAIL match_activity k=%0d got=%b%b want=%b", k, o_active[k], o_pv[k], e_act);
            end
        end
    endtask

    task automatic test_reset_mid_window();
        int t0;
        do_reset(); clear_stim();
        t0 = $urandom_range(2, 5);
        s_irv[t0] = 1'b1; s_code[t0] = LUNGE; s_dist[t0 + 1] = 11'($urandom_range(0, 100));
        run_steps(t0 + 3);
        checks++;
        if (o_touch[t0 + 1] !== 1'b1) begin
            failures++; $display("FAIL midwin_touch got=%b want=1", o_touch[t0 + 1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({action, active, defending, cooldown, touch, pv, who, ps, os, mo} !== 14'd0) begin
            failures++; $display("FAIL midwin_reset got=%b want=0", {action, active, defending, cooldown, touch, pv, who, ps, os, mo});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_stim();
        run_steps(20);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (o_pv[k] !== 1'b0 || o_ps[k] !== 2'd0 || o_touch[k] !== 1'b0) begin
                failures++; $display("FAIL midwin_after k=%0d got=%b/%0d/%b want=0", k, o_pv[k], o_ps[k], o_touch[k]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_inputs();
        test_reset();
        test_lunge_lands();
        test_blocked_lunge();
        test_double_touch();
        test_reach_boundary();
        test_match_over();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
